// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU-side memory access path.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_WORD_W = 2 * DEF_BYTE_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAP   = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Byte/word load-store sequencer in front of a byte-wide synchronous memory.
// Define MEM_ALIGN_CHECK_EN to reject odd-address word requests with err instead of accessing memory.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYTE_W = DEF_BYTE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_word,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*BYTE_W-1:0]   req_wdata,
    output logic                  done,
    output logic [2*BYTE_W-1:0]   rdata,
    output logic                  err,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BYTE_W-1:0]     mem_wdata,
    input  logic [BYTE_W-1:0]     mem_rdata
);

    localparam int WORD_W = 2 * BYTE_W;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is registered and is high only in IDLE, so payload is latched at that edge
    // and later input changes cannot disturb the transfer in flight.
    state_t              state;
    logic                lat_word;
    logic [ADDR_W-1:0]   lat_addr;
    logic [BYTE_W-1:0]   lat_whi;
    logic                idx;
`ifdef MEM_ALIGN_CHECK_EN
    logic                err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_word  <= 1'b0;
            lat_addr  <= '0;
            lat_whi   <= '0;
            idx       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_word  <= req_word;
                        lat_addr  <= req_addr;
                        lat_whi   <= req_wdata[WORD_W-1:BYTE_W];
                        idx       <= 1'b0;
                        req_ready <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        if (req_word && req_addr[0]) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err_q <= 1'b1;
                        end else
`endif
                        if (req_write) begin
                            state     <= WR;
                            MemWrite  <= 1'b1;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata[BYTE_W-1:0];
                        end else begin
                            state    <= RD_ISSUE;
                            MemRead  <= 1'b1;
                            mem_addr <= req_addr;
                            // A byte load returns zero-extended data.
                            if (!req_word)
                                rdata[WORD_W-1:BYTE_W] <= '0;
                        end
                    end
                end
                RD_ISSUE: begin
                    MemRead <= 1'b0;
                    state   <= RD_CAP;
                end
                RD_CAP: begin
                    if (idx)
                        rdata[WORD_W-1:BYTE_W] <= mem_rdata;
                    else
                        rdata[BYTE_W-1:0] <= mem_rdata;
                    if (lat_word && !idx) begin
                        idx      <= 1'b1;
                        state    <= RD_ISSUE;
                        MemRead  <= 1'b1;
                        mem_addr <= lat_addr + ADDR_W'(1);
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WR: begin
                    if (lat_word && !idx) begin
                        idx       <= 1'b1;
                        mem_addr  <= lat_addr + ADDR_W'(1);
                        mem_wdata <= lat_whi;
                    end else begin
                        MemWrite <= 1'b0;
                        state    <= DONE;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    err_q     <= 1'b0;
`endif
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    done      <= 1'b0;
                    MemRead   <= 1'b0;
                    MemWrite  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural 256 x 8 synchronous memory.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        done;
    logic [15:0] rdata;
    logic        err;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_word  (req_word),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Clock and memory model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (MemWrite) mem[mem_addr] <= mem_wdata;
        if (MemRead)  mem_rdata <= mem[mem_addr];
    end

    // Scoreboard state.
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_wr_q[$];
    logic [15:0] model_rdata;
    logic        done_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Continuous monitors: strobe exclusivity, store strobes, single-cycle done.
    always @(negedge clk) begin
        if (!reset) begin
            check("strobe_excl", {31'd0, MemRead & MemWrite}, 32'd0);
            if (MemWrite) begin
                if (exp_wr_q.size() == 0)
                    check("unexpected_write", {16'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                else
                    check("write_addr_data", {16'd0, mem_addr, mem_wdata}, {16'd0, exp_wr_q.pop_front()});
            end
            if (done) check("done_pulse", {31'd0, done_prev}, 32'd0);
        end
        done_prev <= done;
    end

    // Driver: issue one request, hold req_valid with scrambled payload while busy, score result.
    task automatic do_req(input logic w, input logic wd, input logic [7:0] a, input logic [15:0] d);
        int          n;
        int          exp_lat;
        logic        exp_err;
        logic        is_rd;
        logic [7:0]  a1;
        a1      = a + 8'd1;
        exp_err = 1'b0;
        is_rd   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (wd && a[0]) begin
            exp_err = 1'b1;
            exp_lat = 1;
            is_rd   = 1'b1;
            exp_q.push_back(model_rdata);
        end else
`endif
        if (w) begin
            exp_lat = wd ? 3 : 2;
            exp_wr_q.push_back({a, d[7:0]});
            ref_mem[a] = d[7:0];
            if (wd) begin
                exp_wr_q.push_back({a1, d[15:8]});
                ref_mem[a1] = d[15:8];
            end
        end else begin
            exp_lat     = wd ? 5 : 3;
            is_rd       = 1'b1;
            model_rdata = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
            exp_q.push_back(model_rdata);
        end
        req_valid = 1'b1;
        req_write = w;
        req_word  = wd;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        #1;
        req_write = 1'($urandom_range(0, 1));
        req_word  = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom_range(0, 255));
        req_wdata = 16'($urandom_range(0, 65535));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("ready_busy", {31'd0, req_ready}, 32'd0);
        end while (!done && n < 20);
        check("latency", n, exp_lat);
        if (done) begin
            check("err", {31'd0, err}, {31'd0, exp_err});
            if (is_rd && exp_q.size() > 0)
                check("rdata", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem_rdata   = 8'h00;
        model_rdata = 16'h0000;
        done_prev   = 1'b0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_word    = 1'b0;
        req_addr    = 8'h00;
        req_wdata   = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check("rst_mem_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
        reset = 1'b0;

        // Directed cases, issued back to back with req_valid held high.
        do_req(1'b1, 1'b0, 8'h10, 16'h77A5);
        do_req(1'b0, 1'b0, 8'h10, 16'h0000);
        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF);
        do_req(1'b0, 1'b1, 8'h20, 16'h0000);
        do_req(1'b1, 1'b1, 8'hFF, 16'h1234);
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000);
        do_req(1'b0, 1'b0, 8'h00, 16'h0000);
        do_req(1'b0, 1'b1, 8'h31, 16'h0000);
        do_req(1'b0, 1'b1, 8'h30, 16'h0000);

        // Random mix of loads and stores.
        for (int i = 0; i < 24; i++)
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        req_valid = 1'b0;

        // Reset during the first RD_CAP of a word load.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_word  = 1'b1;
        req_addr  = 8'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_issue", {31'd0, MemRead}, 32'd1);
        @(negedge clk);
        check("rd_cap", {31'd0, MemRead}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = 16'h0000;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_quiet", {30'd0, done, MemRead}, 32'd0);
        end
        do_req(1'b0, 1'b0, 8'h10, 16'h0000);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_q_empty", exp_wr_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer that sits directly upstream of the 256 x 8-bit synchronous memory and is its only master.
- Accepts byte or 16-bit word load/store requests from the CPU core over a valid/ready handshake.
- Splits each request into byte-wide MemRead/MemWrite cycles and reassembles load data.
- Returns a one-cycle done pulse with the result.

Parameters:
- ADDR_W, 8, byte address width. Must match the memory; the address space is 2^ADDR_W bytes.
- BYTE_W, 8, memory data width. Words are 2*BYTE_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_word  in  1  1 = 16-bit word, 0 = byte.
- req_addr  in  ADDR_W  byte address (low byte of a word).
- req_wdata  in  2*BYTE_W  store data; bits [7:0] only for a byte store.
- done  out  1  one-cycle completion pulse.
- rdata  out  2*BYTE_W  load result, valid while done=1. A byte load is zero-extended.
- err  out  1  misaligned-access flag, valid while done=1 (ALIGN_CHECK_EN only; otherwise tied 0).
- MemRead  out  1  to memory.
- MemWrite  out  1  to memory.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  BYTE_W  to memory data_in.
- mem_rdata  in  BYTE_W  from memory data_out, registered by the memory.

Behaviour:
- Reset: state=IDLE; req_ready=1; done=0; err=0; rdata=0; MemRead=0; MemWrite=0; mem_addr=0; mem_wdata=0. Reset mid-transfer aborts immediately: no further memory strobes and no done pulse.
- Accept on the rising edge where req_valid && req_ready. Latch write, word, addr, wdata and a byte index (0 = low byte). Inputs are ignored while busy.
- FSM states: IDLE, RD_ISSUE, RD_CAP, WR, DONE. Memory strobes and address/data are registered outputs decoded from state (Moore).
- RD_ISSUE: MemRead=1, mem_addr = addr + index. The memory latches mem_rdata at the end of this cycle. Next state is RD_CAP.
- RD_CAP: MemRead=0; capture mem_rdata into rdata byte[index] at the end of the cycle.
  - Word load with index 0: set index=1, go to RD_ISSUE.
  - Otherwise: go to DONE.
- WR: MemWrite=1, mem_addr = addr + index, mem_wdata = wdata byte[index].
  - Word store with index 0: set index=1, stay in WR.
  - Otherwise: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. req_ready=0 during DONE. The earliest next acceptance is the edge that ends DONE's following cycle in IDLE.
- MemRead and MemWrite are never both 1.
- Latency, in cycles from the acceptance edge to done high:
  - byte load: 3 (ISSUE, CAP, DONE)
  - word load: 5
  - byte store: 2
  - word store: 3
- Byte ordering is little-endian: the low byte is at addr, the high byte at addr+1.
- Address arithmetic is modulo 2^ADDR_W, so a word at 0xFF uses 0xFF then 0x00.
- rdata holds its value after done until the next load's first capture. For a byte load the upper byte is cleared at acceptance.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a word request with req_addr[0]=1 performs no memory access. FSM goes IDLE -> DONE, with done=1, err=1 and rdata unchanged. Latency is 1.
- Not defined: err is constant 0, and misaligned words proceed with wrap-around as above.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum (IDLE, RD_ISSUE, RD_CAP, WR, DONE)
  - ADDR_W and BYTE_W defaults
  - WORD_W = 2*BYTE_W
- No sub-module. A single FSM plus datapath registers is the natural size, around 200 lines.

Test Plan:
- Byte store then load: store addr 0x10, wdata 0x00A5; then load byte 0x10 -> MemWrite for one cycle at 0x10 with 0xA5; load done 3 cycles after acceptance with rdata=0x00A5.
- Word round-trip: store word 0x20 = 0xBEEF -> writes 0xEF at 0x20, then 0xBE at 0x21; word load 0x20 -> rdata=0xBEEF at done, 5 cycles after acceptance.
- Wrap-around (macro off): store word 0xFF = 0x1234 -> 0x34 at 0xFF, 0x12 at 0x00; word load 0xFF returns 0x1234.
- Handshake: hold req_valid continuously with changing payloads -> exactly one acceptance per IDLE cycle; req_ready=0 from accept through DONE; in-flight payload unaffected by input changes.
- Reset mid-operation: assert reset in the first RD_CAP of a word load -> next cycle IDLE, req_ready=1, MemRead=0, no done pulse; a following byte load completes normally.
- Alignment (macro on): word load at 0x31 -> no MemRead, done=1 and err=1 one cycle after acceptance; a word at 0x30 completes with err=0.
